// File: rtl/hci_package.sv
// Shared types and constants for the HWPE-side HCI arbiter.
package hci_package;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } hci_arb_state_e;

  localparam int unsigned HCI_ARB_STAT_W = 32;

endpackage

// File: rtl/hci_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, with wrap-around.
module hci_rr_pick
  import hci_package::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             found_o
);

  int unsigned j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!found_o && req_i[j]) begin
        idx_o   = PTR_W'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hci_hwpe_arbiter.sv
// Round-robin, burst-locking arbiter sharing one wide HCI port among NB_REQ HWPE requesters.
// Optional per-requester grant counters when HCI_HWPE_ARB_STATS_EN is defined.
module hci_hwpe_arbiter
  import hci_package::*;
#(
  parameter int unsigned NB_REQ    = 2,
  parameter int unsigned DW        = 128,
  parameter int unsigned AW        = 32,
  parameter int unsigned BW        = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [NB_REQ-1:0]        req_i,
  input  logic [NB_REQ*AW-1:0]     add_i,
  input  logic [NB_REQ-1:0]        wen_i,
  input  logic [NB_REQ*DW/BW-1:0]  be_i,
  input  logic [NB_REQ*DW-1:0]     data_i,
  output logic [NB_REQ-1:0]        gnt_o,
  output logic [NB_REQ-1:0]        r_valid_o,
  output logic [DW-1:0]            r_data_o,
  output logic                     out_req_o,
  output logic [AW-1:0]            out_add_o,
  output logic                     out_wen_o,
  output logic [DW/BW-1:0]         out_be_o,
  output logic [DW-1:0]            out_data_o,
  input  logic                     out_gnt_i,
  input  logic                     out_r_valid_i,
  input  logic [DW-1:0]            out_r_data_i
`ifdef HCI_HWPE_ARB_STATS_EN
  ,
  output logic [NB_REQ*HCI_ARB_STAT_W-1:0] stat_grants_o
`endif
);

  localparam int unsigned BEW   = DW / BW;
  localparam int unsigned PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  hci_arb_state_e   state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] sel_q, sel_d;
  logic             frz_q, frz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_pend_q, resp_pend_d;
  logic [PTR_W-1:0] resp_id_q, resp_id_d;

  logic [PTR_W-1:0] owner_inc, pick_ptr, pick_idx, sel;
  logic             pick_found, others, owner_keep, use_frz, found, hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NB_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  hci_rr_pick #(
    .N     (NB_REQ),
    .PTR_W (PTR_W)
  ) i_pick (
    .req_i   (req_i),
    .ptr_i   (pick_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Selection: a stalled request stays frozen; the owner keeps the port until its burst is spent.
  always_comb begin
    owner_inc  = ptr_inc(owner_q);
    others     = |(req_i & ~(NB_REQ'(1) << owner_q));
    owner_keep = (state_q == ARB_LOCKED) && req_i[owner_q] &&
                 ((cnt_q < CNT_W'(MAX_BURST)) || !others);
    pick_ptr   = (state_q == ARB_LOCKED) ? owner_inc : rr_ptr_q;
    use_frz    = frz_q && req_i[sel_q];
    if (use_frz) begin
      sel   = sel_q;
      found = 1'b1;
    end else if (owner_keep) begin
      sel   = owner_q;
      found = 1'b1;
    end else begin
      sel   = pick_idx;
      found = pick_found;
    end
    hs = rst_ni && found && out_gnt_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      sel_q       <= '0;
      frz_q       <= 1'b0;
      cnt_q       <= '0;
      resp_pend_q <= 1'b0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      frz_q       <= frz_d;
      cnt_q       <= cnt_d;
      resp_pend_q <= resp_pend_d;
      resp_id_q   <= resp_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    sel_d       = sel;
    frz_d       = found && !out_gnt_i;
    resp_pend_d = hs;
    resp_id_d   = hs ? sel : resp_id_q;

    if ((state_q == ARB_LOCKED) && !owner_keep) begin
      state_d  = ARB_IDLE;
      rr_ptr_d = owner_inc;
    end

    if (hs) begin
      if (owner_keep && (sel == owner_q)) begin
        cnt_d = (cnt_q == CNT_W'(MAX_BURST)) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      end else begin
        state_d = ARB_LOCKED;
        owner_d = sel;
        cnt_d   = CNT_W'(1);
      end
    end

    if (clear_i) begin
      state_d  = ARB_IDLE;
      rr_ptr_d = '0;
      cnt_d    = '0;
      frz_d    = 1'b0;
    end
  end

  // Output muxing and response routing; everything but read data is held at zero in reset.
  always_comb begin
    out_req_o  = rst_ni && found;
    out_add_o  = '0;
    out_wen_o  = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    gnt_o      = '0;
    r_valid_o  = '0;
    r_data_o   = out_r_data_i;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (rst_ni && (sel == PTR_W'(i))) begin
        out_add_o  = add_i[i*AW +: AW];
        out_wen_o  = wen_i[i];
        out_be_o   = be_i[i*BEW +: BEW];
        out_data_o = data_i[i*DW +: DW];
        gnt_o[i]   = hs;
      end
      r_valid_o[i] = rst_ni && out_r_valid_i && resp_pend_q && (resp_id_q == PTR_W'(i));
    end
  end

`ifdef HCI_HWPE_ARB_STATS_EN
  logic [HCI_ARB_STAT_W-1:0] stat_q [NB_REQ];

  // Saturating per-requester handshake counters
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (!rst_ni || clear_i) begin
        stat_q[i] <= '0;
      end else if (gnt_o[i] && (stat_q[i] != '1)) begin
        stat_q[i] <= stat_q[i] + HCI_ARB_STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_grants_o = '0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      stat_grants_o[i*HCI_ARB_STAT_W +: HCI_ARB_STAT_W] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_hci_hwpe_arbiter.sv
// Scoreboard bench for hci_hwpe_arbiter: directed scenarios push expected grants/responses,
// a negedge monitor pops and compares whenever the DUT grants or returns a response.
module tb_hci_hwpe_arbiter;

  logic          clk = 1'b0;
  logic          rst_n, clear;
  logic [1:0]    req, wen, gnt, r_valid;
  logic [63:0]   add;
  logic [31:0]   be;
  logic [255:0]  data;
  logic [127:0]  r_data, out_data, out_r_data;
  logic          out_req, out_wen, out_gnt, out_r_valid;
  logic [31:0]   out_add;
  logic [15:0]   out_be;
`ifdef HCI_HWPE_ARB_STATS_EN
  logic [63:0]   stat;
`endif

  always #5 clk = ~clk;

  hci_hwpe_arbiter #(
    .NB_REQ(2), .DW(128), .AW(32), .BW(8), .MAX_BURST(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .req_i(req), .add_i(add), .wen_i(wen), .be_i(be), .data_i(data),
    .gnt_o(gnt), .r_valid_o(r_valid), .r_data_o(r_data),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen),
    .out_be_o(out_be), .out_data_o(out_data),
    .out_gnt_i(out_gnt), .out_r_valid_i(out_r_valid), .out_r_data_i(out_r_data)
`ifdef HCI_HWPE_ARB_STATS_EN
    , .stat_grants_o(stat)
`endif
  );

  typedef struct { int id; logic [31:0] ad; } gexp_t;
  typedef struct { int id; logic [127:0] d; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] a [2];
  int left [2];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expg(input int id, input logic [31:0] ad, input bit resp);
    gexp_t g;
    rexp_t r;
    g.id = id; g.ad = ad;
    gq.push_back(g);
    if (resp) begin
      r.id = id; r.d = {4{ad}};
      rq.push_back(r);
    end
  endtask

  task automatic drive();
    add  = {a[1], a[0]};
    data = {{4{a[1] ^ 32'h5A5A_0000}}, {4{a[0] ^ 32'h5A5A_0000}}};
    be   = {16'h0F0F, 16'hFFFF};
    wen  = 2'b01;
  endtask

  task automatic start(input int i, input logic [31:0] base, input int n);
    a[i] = base; left[i] = n; req[i] = 1'b1;
    drive();
  endtask

  // One clock: requesters advance on their grant; the port answers one cycle after a handshake.
  task automatic step();
    logic [1:0]  g;
    logic        h;
    logic [31:0] ad;
    #1;
    g = gnt; h = out_req & out_gnt; ad = out_add;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        a[i] = a[i] + 32'h10;
        left[i]--;
        if (left[i] == 0) req[i] = 1'b0;
      end
    end
    out_r_valid = h;
    out_r_data  = h ? {4{ad}} : 128'h0;
    drive();
  endtask

  task automatic run(input int max, output int k);
    k = 0;
    while (req != 2'b00 && k < max) begin
      step();
      k++;
    end
    if (req != 2'b00) check("run_timeout", 256'(req), 256'(0));
    step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Monitor: every grant or response the DUT presents is matched against the head of its queue.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (gnt != 2'b00) begin
      if (gq.size() == 0) check("gnt_unexpected", 256'(gnt), 256'(0));
      else begin
        g = gq.pop_front();
        check("gnt_id", 256'(gnt), 256'(2'b01) << g.id);
        check("gnt_add", 256'(out_add), 256'(g.ad));
        check("gnt_wen", 256'(out_wen), 256'(g.id == 0));
        check("gnt_be", 256'(out_be), 256'((g.id == 0) ? 16'hFFFF : 16'h0F0F));
        check("gnt_data", 256'(out_data), 256'({4{g.ad ^ 32'h5A5A_0000}}));
      end
    end
    if (r_valid != 2'b00) begin
      if (rq.size() == 0) check("rvalid_unexpected", 256'(r_valid), 256'(0));
      else begin
        r = rq.pop_front();
        check("rvalid_id", 256'(r_valid), 256'(2'b01) << r.id);
        check("rdata", 256'(r_data), 256'(r.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; clear = 1'b0; req = 2'b11; out_gnt = 1'b1;
    a[0] = 32'h0; a[1] = 32'h0; left[0] = 0; left[1] = 0;
    out_r_valid = 1'b1; out_r_data = 128'hABC;
    drive();

    // Reset: outputs held low, read data passes through
    @(posedge clk); #2;
    check("rst_out_req", 256'(out_req), 256'(0));
    check("rst_gnt", 256'(gnt), 256'(0));
    check("rst_rvalid", 256'(r_valid), 256'(0));
    check("rst_out_add", 256'(out_add), 256'(0));
    check("rst_rdata", 256'(r_data), 256'(128'hABC));
    req = 2'b00; out_r_valid = 1'b0; out_r_data = 128'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester: three reads in consecutive cycles
    expg(0, 32'h100, 1); expg(0, 32'h110, 1); expg(0, 32'h120, 1);
    start(0, 32'h100, 3);
    #1 check("s1_zero_latency_gnt", 256'(gnt), 256'(2'b01));
    run(10, k);
    check("s1_cycles", 256'(k), 256'(3));
    pulse_clear();

    // Two continuous requesters, MAX_BURST=4
    for (int i = 0; i < 4; i++) expg(0, 32'h1000 + 32'(i * 16), 1);
    for (int i = 0; i < 4; i++) expg(1, 32'h2000 + 32'(i * 16), 1);
    expg(0, 32'h1040, 1); expg(0, 32'h1050, 1);
    expg(1, 32'h2040, 1); expg(1, 32'h2050, 1);
    start(0, 32'h1000, 6); start(1, 32'h2000, 6);
    run(30, k);
    check("s2_cycles", 256'(k), 256'(12));
    pulse_clear();

    // Owner 1 drops after two grants while 0 waits
    expg(1, 32'h2000, 1); expg(1, 32'h2010, 1); expg(0, 32'h1000, 1);
    start(1, 32'h2000, 2);
    step();
    start(0, 32'h1000, 1);
    step();
    #1 check("s3_next_gnt", 256'(gnt), 256'(2'b01));
    run(10, k);

    // Stall with rr_ptr=1: frozen requester 0 still goes first
    expg(0, 32'h1100, 1); expg(1, 32'h2100, 1);
    out_gnt = 1'b0;
    start(0, 32'h1100, 1);
    #1 check("s4_stall_req", 256'(out_req), 256'(1));
    check("s4_stall_gnt", 256'(gnt), 256'(0));
    step();
    start(1, 32'h2100, 1);
    step();
    step();
    out_gnt = 1'b1;
    #1 check("s4_frozen_first", 256'(gnt), 256'(2'b01));
    run(10, k);
    pulse_clear();

    // Reset right after a handshake drops the response and the lock
    expg(1, 32'h2200, 0);
    start(1, 32'h2200, 2);
    step();
    rst_n = 1'b0;
    #1 check("s5_rvalid_dropped", 256'(r_valid), 256'(0));
    check("s5_out_req", 256'(out_req), 256'(0));
    step();
    rst_n = 1'b1;
    expg(0, 32'h3000, 1); expg(1, 32'h2210, 1);
    start(0, 32'h3000, 1);
    #1 check("s5_restart_gnt", 256'(gnt), 256'(2'b01));
    run(10, k);

    // Clear after a handshake: response still delivered, selection restarts at 0
    expg(1, 32'h2300, 1); expg(0, 32'h3100, 1); expg(1, 32'h2310, 1);
    start(1, 32'h2300, 2);
    step();
    clear = 1'b1; out_gnt = 1'b0;
    start(0, 32'h3100, 1);
    step();
    clear = 1'b0; out_gnt = 1'b1;
    #1 check("s6_restart_gnt", 256'(gnt), 256'(2'b01));
    run(10, k);

    step(); step();
    check("gq_empty", 256'(gq.size()), 256'(0));
    check("rq_empty", 256'(rq.size()), 256'(0));
`ifdef HCI_HWPE_ARB_STATS_EN
    check("stat0", 256'(stat[31:0]), 256'(1));
    check("stat1", 256'(stat[63:32]), 256'(1));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
